// File: rtl/jtag_link_ctrl.sv
// User-clock side of the JTAG virtual-UART link: round-robin TX arbiter into the outbound FIFO, RX drain of the inbound FIFO.
// Optional JTAG_LINK_STATS_EN adds 16-bit tx/rx byte counters.
module jtag_link_ctrl #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] data_i,
  input  logic [NREQ-1:0]   last_i,
  output logic [NREQ-1:0]   gnt_o,
  input  logic              fifo_wrfull_i,
  output logic              fifo_wr_o,
  output logic [7:0]        fifo_data_o,
  input  logic              fifo_rdempty_i,
  input  logic [7:0]        fifo_q_i,
  output logic              fifo_rd_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic [2:0]        owner_o
`ifdef JTAG_LINK_STATS_EN
  ,
  output logic [15:0]       tx_count_o,
  output logic [15:0]       rx_count_o
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] owner, owner_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic       own_req, own_last;
  logic [7:0] own_dat;
  logic       accept;
  logic       found;
  logic [2:0] win;
  logic [3:0] cand;
  logic       rd_pend;

  // Owner lane mux; loop compare keeps index widths clean for any NREQ.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_dat  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 3'(i)) begin
        own_req  = req_i[i];
        own_last = last_i[i];
        own_dat  = data_i[8*i +: 8];
      end
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = 4'h0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 4'(ptr) + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && cand == 4'(i) && req_i[i]) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_o     = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = win;
          ptr_nxt   = win;
          cnt_nxt   = 8'h00;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        for (int i = 0; i < NREQ; i++) begin
          if (owner == 3'(i)) gnt_o[i] = !fifo_wrfull_i;
        end
        accept = own_req && !fifo_wrfull_i;
        if (accept) cnt_nxt = cnt + 8'd1;
        if (!own_req || (accept && (own_last || (cnt + 8'd1) == 8'(MAXBURST))))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_wr_o   = accept;
  assign fifo_data_o = own_dat;
  assign busy_o      = (state == GRANT);
  assign owner_o     = owner;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= 3'd0;
      ptr   <= 3'(NREQ-1);
      cnt   <= 8'h00;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A read is only issued when the output slot will be free by the time the data lands.
  assign fifo_rd_o = !fifo_rdempty_i && !rd_pend && (!rx_valid_o || rx_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend    <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= 8'h00;
    end else begin
      rd_pend <= fifo_rd_o;
      if (rd_pend) begin
        rx_data_o  <= fifo_q_i;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

`ifdef JTAG_LINK_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_count_o <= 16'h0000;
      rx_count_o <= 16'h0000;
    end else begin
      if (fifo_wr_o) tx_count_o <= tx_count_o + 16'd1;
      if (rx_valid_o && rx_ready_i) rx_count_o <= rx_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_link_ctrl.sv
// Directed bench for jtag_link_ctrl: arbitration order, burst limit, FIFO full, requester drop, RX drain.
module tb_jtag_link_ctrl;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, last, gnt;
  logic [31:0] data;
  logic        wrfull, fifo_wr, rdempty, fifo_rd, rx_valid, rx_ready, busy;
  logic [7:0]  fifo_data, fifo_q, rx_data;
  logic [2:0]  owner;
`ifdef JTAG_LINK_STATS_EN
  logic [15:0] tx_count, rx_count;
`endif

  always #5 clk = ~clk;

  jtag_link_ctrl #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .last_i(last), .gnt_o(gnt),
    .fifo_wrfull_i(wrfull), .fifo_wr_o(fifo_wr), .fifo_data_o(fifo_data),
    .fifo_rdempty_i(rdempty), .fifo_q_i(fifo_q), .fifo_rd_o(fifo_rd),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .busy_o(busy), .owner_o(owner)
`ifdef JTAG_LINK_STATS_EN
    , .tx_count_o(tx_count), .rx_count_o(rx_count)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic exp_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_wr"}, 32'(fifo_wr), 32'd0);
  endtask

  task automatic exp_wr(input string tag, input logic [3:0] g, input logic [7:0] d);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_wr"}, 32'(fifo_wr), 32'd1);
    check({tag, "_dat"}, 32'(fifo_data), 32'(d));
  endtask

  logic [7:0] mem[$];
  logic [7:0] rx_exp[3];
  logic       rd_seen;
  int         nrx;
`ifdef JTAG_LINK_STATS_EN
  int         nw;
`endif

  initial begin
    rst = 1'b1; req = '0; last = '0; data = '0; wrfull = 1'b0;
    rdempty = 1'b1; fifo_q = 8'h00; rx_ready = 1'b0;
    rx_exp[0] = 8'hA5; rx_exp[1] = 8'h5A; rx_exp[2] = 8'h3C;

    sample();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wr", 32'(fifo_wr), 32'd0);
    check("rst_rd", 32'(fifo_rd), 32'd0);
    check("rst_rxv", 32'(rx_valid), 32'd0);
    check("rst_rxd", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);

    // All four request single-byte packets: 0,1,2,3,0 with an idle cycle between grants.
    tick();
    rst = 1'b0; req = 4'b1111; last = 4'b1111; data = 32'h13121110;
    sample();
    exp_idle("rr_idle0");
    for (int n = 0; n < 5; n++) begin
      tick();
      sample();
      exp_wr("rr_wr", 4'(1 << (n % 4)), 8'(8'h10 + n % 4));
      check("rr_owner", 32'(owner), 32'(n % 4));
      tick();
      if (n == 4) req = 4'b0000;
      sample();
      exp_idle("rr_gap");
    end

    // Requester 2 streams 20 bytes; burst limit splits it 16 + 4.
    tick();
    req = 4'b0100; last = 4'b0000; data[23:16] = 8'd0;
    sample();
    exp_idle("bl_idle0");
    for (int k = 0; k < 16; k++) begin
      tick();
      data[23:16] = 8'(k);
      sample();
      exp_wr("bl_wr1", 4'b0100, 8'(k));
    end
    tick();
    data[23:16] = 8'd16;
    sample();
    exp_idle("bl_release");
    for (int k = 16; k < 20; k++) begin
      tick();
      data[23:16] = 8'(k);
      last[2] = (k == 19);
      sample();
      exp_wr("bl_wr2", 4'b0100, 8'(k));
      check("bl_owner", 32'(owner), 32'd2);
    end
    tick();
    req = 4'b0000; last = 4'b0000;
    sample();
    exp_idle("bl_end");

    // FIFO full for 5 cycles mid-packet on requester 3.
    tick();
    req = 4'b1000;
    sample();
    exp_idle("ff_idle0");
    for (int k = 0; k < 3; k++) begin
      tick();
      data[31:24] = 8'(8'hC0 + k);
      sample();
      exp_wr("ff_wr", 4'b1000, 8'(8'hC0 + k));
    end
    for (int f = 0; f < 5; f++) begin
      tick();
      wrfull = 1'b1; data[31:24] = 8'hC3;
      sample();
      check("ff_gnt", 32'(gnt), 32'd0);
      check("ff_wr0", 32'(fifo_wr), 32'd0);
      check("ff_busy", 32'(busy), 32'd1);
      check("ff_owner", 32'(owner), 32'd3);
    end
    tick();
    wrfull = 1'b0;
    sample();
    exp_wr("ff_resume", 4'b1000, 8'hC3);
    tick();
    data[31:24] = 8'hC4; last[3] = 1'b1;
    sample();
    exp_wr("ff_last", 4'b1000, 8'hC4);
    tick();
    req = 4'b0000; last = 4'b0000;
    sample();
    exp_idle("ff_end");

    // Requester 1 drops after 3 bytes; next search starts after 1.
    tick();
    req = 4'b0010; data[23:16] = 8'h77;
    sample();
    exp_idle("rd_idle0");
    for (int k = 0; k < 3; k++) begin
      tick();
      data[15:8] = 8'(8'h20 + k);
      sample();
      exp_wr("rq_wr", 4'b0010, 8'(8'h20 + k));
    end
    tick();
    req = 4'b0100;
    sample();
    check("rq_drop_wr", 32'(fifo_wr), 32'd0);
    check("rq_drop_busy", 32'(busy), 32'd1);
    tick();
    req = 4'b0110; last = 4'b0100;
    sample();
    exp_idle("rq_idle");
    tick();
    sample();
    exp_wr("rq_next", 4'b0100, 8'h77);
    check("rq_owner", 32'(owner), 32'd2);
    tick();
    req = 4'b0000; last = 4'b0000;
    sample();
    exp_idle("rq_end");

    // RX drain with ready pattern 1,0,0,1.
    rd_seen = 1'b0;
    nrx = 0;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (t == 0) begin
        mem.push_back(8'hA5); mem.push_back(8'h5A); mem.push_back(8'h3C);
        rdempty = 1'b0;
      end else if (rd_seen && mem.size() > 0) begin
        fifo_q = mem.pop_front();
        rdempty = (mem.size() == 0);
      end
      rx_ready = ((t % 4) == 0) || ((t % 4) == 3);
      sample();
      if (t == 1) check("rx_lat1", 32'(rx_valid), 32'd0);
      if (t == 2) check("rx_lat2", 32'(rx_valid), 32'd1);
      if (rx_valid && !rx_ready) check("rx_rd_hold", 32'(fifo_rd), 32'd0);
      if (rx_valid && rx_ready) begin
        if (nrx < 3) check("rx_data", 32'(rx_data), 32'(rx_exp[nrx]));
        else check("rx_extra", 32'(nrx), 32'd2);
        nrx++;
      end
      rd_seen = fifo_rd;
    end
    check("rx_count", 32'(nrx), 32'd3);
    check("rx_idle", 32'(rx_valid), 32'd0);

`ifdef JTAG_LINK_STATS_EN
    check("st_tx", 32'(tx_count), 32'd34);
    check("st_rx", 32'(rx_count), 32'd3);
    tick();
    rst = 1'b1;
    sample();
    check("st_rst_tx", 32'(tx_count), 32'd0);
    tick();
    rst = 1'b0; req = 4'b0001; last = 4'b0000;
    nw = 0;
    for (int c = 0; c < 80000 && nw < 65537; c++) begin
      tick();
      sample();
      if (fifo_wr) nw++;
    end
    tick();
    req = 4'b0000;
    sample();
    check("st_budget", 32'(nw), 32'd65537);
    check("st_wrap", 32'(tx_count), 32'd1);
    tick();
    req = 4'b0010;
    tick();
    tick();
    sample();
    check("st_mid_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("st_ar_tx", 32'(tx_count), 32'd0);
    check("st_ar_rx", 32'(rx_count), 32'd0);
    check("st_ar_gnt", 32'(gnt), 32'd0);
    check("st_ar_wr", 32'(fifo_wr), 32'd0);
    check("st_ar_busy", 32'(busy), 32'd0);
    check("st_ar_owner", 32'(owner), 32'd0);
    tick();
    rst = 1'b0; req = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
